alu_rs: RTL and testbench



---
 rtl/alu_rs.sv | 172 +++++++++++++++++
 tb/tb_alu_rs.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// alu_rs -- reservation station in front of the ALU.
//
// Buffers decoded ALU micro-ops until both operands are known, wakes waiting
// operands from the common data bus (CDB), and issues the oldest-by-index
// ready op into a registered issue stage that drives the ALU directly.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               squash every buffered entry and the issue register
//   disp_*              dispatch request: opcode, operand {rdy,val,tag}, dst tag
//   disp_ready          a free entry exists (from current state only)
//   cdb_valid/tag/data  result broadcast used for operand wakeup
//   alu_en              issue register valid, drives the ALU enable
//   alu_ready           ALU/writeback accepts the issued op this cycle
//   alu_A/alu_B         operands to the ALU
//   alu_ctrl            ALUControl opcode (0 add,1 sub,2 and,3 or,4 sra,5 slt,6 srl,7 xor)
//   alu_dst_tag         destination tag travelling with the result
module alu_rs #(
  parameter int BITWIDTH = 32,
  parameter int NENTRIES = 4,
  parameter int TAGWIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                disp_valid,
  output logic                disp_ready,
  input  logic [2:0]          disp_op,
  input  logic                disp_a_rdy,
  input  logic                disp_b_rdy,
  input  logic [BITWIDTH-1:0] disp_a_val,
  input  logic [BITWIDTH-1:0] disp_b_val,
  input  logic [TAGWIDTH-1:0] disp_a_tag,
  input  logic [TAGWIDTH-1:0] disp_b_tag,
  input  logic [TAGWIDTH-1:0] disp_dst_tag,
  input  logic                cdb_valid,
  input  logic [TAGWIDTH-1:0] cdb_tag,
  input  logic [BITWIDTH-1:0] cdb_data,
  output logic                alu_en,
  input  logic                alu_ready,
  output logic [BITWIDTH-1:0] alu_A,
  output logic [BITWIDTH-1:0] alu_B,
  output logic [2:0]          alu_ctrl,
  output logic [TAGWIDTH-1:0] alu_dst_tag
);

  localparam int IDXW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;

  // Entry storage
  logic [NENTRIES-1:0] valid_reg;
  logic [NENTRIES-1:0] a_rdy_reg;
  logic [NENTRIES-1:0] b_rdy_reg;
  logic [2:0]          op_reg    [NENTRIES];
  logic [TAGWIDTH-1:0] dst_reg   [NENTRIES];
  logic [TAGWIDTH-1:0] a_tag_reg [NENTRIES];
  logic [TAGWIDTH-1:0] b_tag_reg [NENTRIES];
  logic [BITWIDTH-1:0] a_val_reg [NENTRIES];
  logic [BITWIDTH-1:0] b_val_reg [NENTRIES];

  // Per-entry control
  logic [NENTRIES-1:0] eligible;
  logic [NENTRIES-1:0] alloc_here;
  logic [NENTRIES-1:0] issue_here;
  logic [NENTRIES-1:0] a_cap;
  logic [NENTRIES-1:0] b_cap;

  logic [IDXW-1:0]     alloc_idx;
  logic [IDXW-1:0]     pick_idx;
  logic                any_free;
  logic                any_elig;
  logic                disp_fire;
  logic                issue_adv;
  logic                issue_fire;

  // Dispatch operands after same-cycle CDB bypass
  logic                a_rdy_in;
  logic                b_rdy_in;
  logic [BITWIDTH-1:0] a_val_in;
  logic [BITWIDTH-1:0] b_val_in;

  assign eligible = valid_reg & a_rdy_reg & b_rdy_reg;
  assign any_free = ~&valid_reg;
  assign any_elig = |eligible;

  // Lowest-index free slot and lowest-index eligible entry; scanning downward
  // lets the lowest matching index overwrite the higher ones.
  always_comb begin
    alloc_idx = '0;
    pick_idx  = '0;
    for (int i = NENTRIES - 1; i >= 0; i--) begin
      if (!valid_reg[i]) alloc_idx = IDXW'(i);
      if (eligible[i])   pick_idx  = IDXW'(i);
    end
  end

  // disp_ready reflects only current occupancy, so an entry issuing this
  // cycle cannot be refilled until the next one.
  assign disp_ready = ~rst & any_free;
  assign disp_fire  = disp_valid & disp_ready;

  // The issue register advances when empty or when the ALU takes its op.
  assign issue_adv  = ~alu_en | alu_ready;
  assign issue_fire = issue_adv & any_elig;

  assign a_rdy_in = disp_a_rdy | (cdb_valid & (cdb_tag == disp_a_tag));
  assign b_rdy_in = disp_b_rdy | (cdb_valid & (cdb_tag == disp_b_tag));
  assign a_val_in = disp_a_rdy ? disp_a_val : cdb_data;
  assign b_val_in = disp_b_rdy ? disp_b_val : cdb_data;

  genvar gi;
  generate
    for (gi = 0; gi < NENTRIES; gi++) begin : g_entry
      assign alloc_here[gi] = disp_fire  & (alloc_idx == IDXW'(gi));
      assign issue_here[gi] = issue_fire & (pick_idx  == IDXW'(gi));
      assign a_cap[gi] = cdb_valid & valid_reg[gi] & ~a_rdy_reg[gi] & (cdb_tag == a_tag_reg[gi]);
      assign b_cap[gi] = cdb_valid & valid_reg[gi] & ~b_rdy_reg[gi] & (cdb_tag == b_tag_reg[gi]);
    end
  endgenerate

  // Entry update. A slot chosen for allocation is invalid, so it can never
  // also be issuing or capturing in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NENTRIES; i++) begin
      if (rst || flush) begin
        valid_reg[i] <= 1'b0;
      end else if (alloc_here[i]) begin
        valid_reg[i] <= 1'b1;
        op_reg[i]    <= disp_op;
        dst_reg[i]   <= disp_dst_tag;
        a_rdy_reg[i] <= a_rdy_in;
        a_val_reg[i] <= a_val_in;
        a_tag_reg[i] <= disp_a_tag;
        b_rdy_reg[i] <= b_rdy_in;
        b_val_reg[i] <= b_val_in;
        b_tag_reg[i] <= disp_b_tag;
      end else begin
        if (issue_here[i]) valid_reg[i] <= 1'b0;
        if (a_cap[i]) begin
          a_rdy_reg[i] <= 1'b1;
          a_val_reg[i] <= cdb_data;
        end
        if (b_cap[i]) begin
          b_rdy_reg[i] <= 1'b1;
          b_val_reg[i] <= cdb_data;
        end
      end
    end
  end

  // Issue register. Flush only drops the valid bit; payload is don't-care
  // while alu_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_en      <= 1'b0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_ctrl    <= '0;
      alu_dst_tag <= '0;
    end else if (flush) begin
      alu_en <= 1'b0;
    end else if (issue_adv) begin
      alu_en <= any_elig;
      if (any_elig) begin
        alu_A       <= a_val_reg[pick_idx];
        alu_B       <= b_val_reg[pick_idx];
        alu_ctrl    <= op_reg[pick_idx];
        alu_dst_tag <= dst_reg[pick_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;

  localparam int BW = 32;
  localparam int NE = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          disp_valid, disp_ready;
  logic [2:0]    disp_op;
  logic          disp_a_rdy, disp_b_rdy;
  logic [BW-1:0] disp_a_val, disp_b_val;
  logic [TW-1:0] disp_a_tag, disp_b_tag, disp_dst_tag;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [BW-1:0] cdb_data;
  logic          alu_en, alu_ready;
  logic [BW-1:0] alu_A, alu_B;
  logic [2:0]    alu_ctrl;
  logic [TW-1:0] alu_dst_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_rs #(.BITWIDTH(BW), .NENTRIES(NE), .TAGWIDTH(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy),
    .disp_a_val(disp_a_val), .disp_b_val(disp_b_val),
    .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag), .disp_dst_tag(disp_dst_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_en(alu_en), .alu_ready(alu_ready),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl), .alu_dst_tag(alu_dst_tag)
  );

  // ---------------- reference model: station as a list of pending ops ----
  typedef struct {
    bit            v;
    logic [2:0]    op;
    logic [TW-1:0] dst;
    bit            ar, br;
    logic [BW-1:0] av, bv;
    logic [TW-1:0] at, bt;
  } ent_t;

  ent_t          m [NE];
  bit            m_en;
  logic [BW-1:0] m_A, m_B;
  logic [2:0]    m_ctrl;
  logic [TW-1:0] m_dtag;

  // One clock of the station's rules, applied to the inputs present at the edge.
  task automatic model_step();
    ent_t nxt [NE];
    int pick = -1;
    int slot = -1;
    if (rst) begin
      foreach (m[i]) m[i].v = 0;
      m_en = 0; m_A = '0; m_B = '0; m_ctrl = '0; m_dtag = '0;
      return;
    end
    if (flush) begin
      foreach (m[i]) m[i].v = 0;
      m_en = 0;
      return;
    end
    for (int i = 0; i < NE; i++) begin
      if (pick < 0 && m[i].v && m[i].ar && m[i].br) pick = i;
      if (slot < 0 && !m[i].v) slot = i;
    end
    nxt = m;
    if (!m_en || alu_ready) begin
      if (pick >= 0) begin
        m_en = 1; m_A = m[pick].av; m_B = m[pick].bv;
        m_ctrl = m[pick].op; m_dtag = m[pick].dst;
        nxt[pick].v = 0;
      end else begin
        m_en = 0;
      end
    end
    if (cdb_valid) begin
      for (int i = 0; i < NE; i++) begin
        if (m[i].v && !m[i].ar && m[i].at == cdb_tag) begin nxt[i].ar = 1; nxt[i].av = cdb_data; end
        if (m[i].v && !m[i].br && m[i].bt == cdb_tag) begin nxt[i].br = 1; nxt[i].bv = cdb_data; end
      end
    end
    if (disp_valid && slot >= 0) begin
      nxt[slot].v   = 1;
      nxt[slot].op  = disp_op;
      nxt[slot].dst = disp_dst_tag;
      nxt[slot].at  = disp_a_tag;
      nxt[slot].bt  = disp_b_tag;
      nxt[slot].ar  = disp_a_rdy || (cdb_valid && cdb_tag == disp_a_tag);
      nxt[slot].br  = disp_b_rdy || (cdb_valid && cdb_tag == disp_b_tag);
      nxt[slot].av  = disp_a_rdy ? disp_a_val : cdb_data;
      nxt[slot].bv  = disp_b_rdy ? disp_b_val : cdb_data;
    end
    m = nxt;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; disp_valid = 0; disp_op = 0;
    disp_a_rdy = 0; disp_b_rdy = 0; disp_a_val = 0; disp_b_val = 0;
    disp_a_tag = 0; disp_b_tag = 0; disp_dst_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic set_disp(input logic [2:0] op, input logic ar, input logic [BW-1:0] av,
                          input logic [TW-1:0] at, input logic br, input logic [BW-1:0] bv,
                          input logic [TW-1:0] bt, input logic [TW-1:0] dst);
    disp_valid = 1; disp_op = op;
    disp_a_rdy = ar; disp_a_val = av; disp_a_tag = at;
    disp_b_rdy = br; disp_b_val = bv; disp_b_tag = bt;
    disp_dst_tag = dst;
  endtask

  task automatic do_reset();
    clear_inputs();
    alu_ready = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    alu_ready = 1;
    rst = 1;
    tick();
    tick();
    checks++;
    if ({alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got en=%0b A=%h B=%h ctrl=%0d dst=%0d, expected all zero",
               alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag);
    end
    checks++;
    if (disp_ready !== 1'b0) begin
      failures++; $display("FAIL reset_disp_ready_low: got %b expected 0", disp_ready);
    end
    rst = 0;
    #1;
    checks++;
    if (disp_ready !== 1'b1) begin
      failures++; $display("FAIL reset_disp_ready_high: got %b expected 1", disp_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_issue();
    do_reset();
    set_disp(3'd0, 1, 32'd5, 0, 1, 32'd3, 0, 4'd2);
    tick();
    clear_inputs();
    checks++;
    if (alu_en !== 1'b0 || disp_ready !== 1'b1) begin
      failures++; $display("FAIL basic_latency1: got en=%b rdy=%b expected en=0 rdy=1", alu_en, disp_ready);
    end
    tick();
    checks++;
    if ({alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag, disp_ready} !== {1'b1, 32'd5, 32'd3, 3'd0, 4'd2, 1'b1}) begin
      failures++;
      $display("FAIL basic_issue: got en=%b A=%0d B=%0d ctrl=%0d dst=%0d rdy=%b expected 1 5 3 0 2 1",
               alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag, disp_ready);
    end
    $display("test_basic_issue: add 5,3 -> dst %0d", alu_dst_tag);
  endtask

  task automatic test_cdb_wakeup();
    do_reset();
    set_disp(3'd1, 1, 32'd7, 0, 0, 32'd0, 4'd9, 4'd1);
    tick();
    clear_inputs();
    tick();
    tick();
    checks++;
    if (alu_en !== 1'b0) begin
      failures++; $display("FAIL wakeup_waiting: got en=%b expected 0", alu_en);
    end
    cdb_valid = 1; cdb_tag = 4'd9; cdb_data = 32'd4;
    tick();
    clear_inputs();
    checks++;
    if (alu_en !== 1'b0) begin
      failures++; $display("FAIL wakeup_edge: got en=%b expected 0", alu_en);
    end
    tick();
    checks++;
    if ({alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag} !== {1'b1, 32'd7, 32'd4, 3'd1, 4'd1}) begin
      failures++;
      $display("FAIL wakeup_issue: got en=%b A=%0d B=%0d ctrl=%0d dst=%0d expected 1 7 4 1 1",
               alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag);
    end
    $display("test_cdb_wakeup: sub issued B=%0d", alu_B);
  endtask

  task automatic test_dispatch_bypass();
    do_reset();
    set_disp(3'd2, 1, 32'h1234_5678, 0, 0, 32'd0, 4'd3, 4'd6);
    cdb_valid = 1; cdb_tag = 4'd3; cdb_data = 32'hFFFF_FFFF;
    tick();
    clear_inputs();
    checks++;
    if (alu_en !== 1'b0) begin
      failures++; $display("FAIL bypass_latency: got en=%b expected 0", alu_en);
    end
    tick();
    checks++;
    if ({alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag} !== {1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 3'd2, 4'd6}) begin
      failures++;
      $display("FAIL bypass_issue: got en=%b A=%h B=%h ctrl=%0d dst=%0d expected 1 12345678 ffffffff 2 6",
               alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag);
    end
    $display("test_dispatch_bypass: B=%h", alu_B);
  endtask

  task automatic test_full_stall();
    logic [TW-1:0] order [4];
    order[0] = 4'd3; order[1] = 4'd2; order[2] = 4'd4; order[3] = 4'd5;
    do_reset();
    alu_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      set_disp(3'(k), 1, BW'(k * 10), 0, 1, BW'(k), 0, TW'(k));
      tick();
    end
    clear_inputs();
    checks++;
    if ({alu_en, alu_A, alu_dst_tag, disp_ready} !== {1'b1, 32'd10, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL full_state: got en=%b A=%0d dst=%0d rdy=%b expected 1 10 1 0", alu_en, alu_A, alu_dst_tag, disp_ready);
    end
    set_disp(3'd7, 1, 32'd60, 0, 1, 32'd6, 0, 4'd6);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag, disp_ready} !== {1'b1, 32'd10, 32'd1, 3'd1, 4'd1, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold: got en=%b A=%0d B=%0d ctrl=%0d dst=%0d rdy=%b expected 1 10 1 1 1 0",
                 alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag, disp_ready);
      end
    end
    clear_inputs();
    alu_ready = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if ({alu_en, alu_dst_tag, alu_A} !== {1'b1, order[j], BW'(order[j] * 10)}) begin
        failures++;
        $display("FAIL drain_order[%0d]: got en=%b dst=%0d A=%0d expected 1 %0d %0d",
                 j, alu_en, alu_dst_tag, alu_A, order[j], order[j] * 10);
      end
    end
    tick();
    checks++;
    if (alu_en !== 1'b0) begin
      failures++; $display("FAIL drain_empty: got en=%b expected 0", alu_en);
    end
    $display("test_full_stall: drained 4 entries");
  endtask

  task automatic test_shared_tag();
    do_reset();
    set_disp(3'd3, 1, 32'h0F0, 0, 0, 32'd0, 4'd7, 4'd4);
    tick();
    set_disp(3'd7, 0, 32'd0, 4'd7, 0, 32'd0, 4'd7, 4'd5);
    tick();
    clear_inputs();
    cdb_valid = 1; cdb_tag = 4'd7; cdb_data = 32'h55;
    tick();
    clear_inputs();
    checks++;
    if (alu_en !== 1'b0) begin
      failures++; $display("FAIL shared_edge: got en=%b expected 0", alu_en);
    end
    tick();
    checks++;
    if ({alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag} !== {1'b1, 32'h0F0, 32'h55, 3'd3, 4'd4}) begin
      failures++;
      $display("FAIL shared_first: got en=%b A=%h B=%h ctrl=%0d dst=%0d expected 1 f0 55 3 4",
               alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag);
    end
    tick();
    checks++;
    if ({alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag} !== {1'b1, 32'h55, 32'h55, 3'd7, 4'd5}) begin
      failures++;
      $display("FAIL shared_second: got en=%b A=%h B=%h ctrl=%0d dst=%0d expected 1 55 55 7 5",
               alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag);
    end
    $display("test_shared_tag: both waiters woken");
  endtask

  task automatic test_flush();
    do_reset();
    alu_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      set_disp(3'd0, 1, BW'(k), 0, 1, BW'(k), 0, TW'(k));
      tick();
    end
    clear_inputs();
    checks++;
    if ({alu_en, alu_dst_tag, disp_ready} !== {1'b1, 4'd1, 1'b1}) begin
      failures++; $display("FAIL flush_pre: got en=%b dst=%0d rdy=%b expected 1 1 1", alu_en, alu_dst_tag, disp_ready);
    end
    flush = 1;
    set_disp(3'd0, 1, 32'd9, 0, 1, 32'd9, 0, 4'd9);
    tick();
    clear_inputs();
    checks++;
    if ({alu_en, disp_ready} !== 2'b01) begin
      failures++; $display("FAIL flush_after: got en=%b rdy=%b expected 0 1", alu_en, disp_ready);
    end
    alu_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (alu_en !== 1'b0) begin
        failures++; $display("FAIL flush_discard[%0d]: got en=%b dst=%0d expected en 0", k, alu_en, alu_dst_tag);
      end
    end
    $display("test_flush: station empty after flush");
  endtask

  task automatic test_random();
    bit exp_dr;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 59) == 0);
      alu_ready  = ($urandom_range(0, 9) < 7);
      disp_valid = $urandom_range(0, 1);
      disp_op    = 3'($urandom);
      disp_a_rdy = $urandom_range(0, 1);
      disp_b_rdy = $urandom_range(0, 1);
      disp_a_val = $urandom;
      disp_b_val = $urandom;
      disp_a_tag = TW'($urandom_range(0, 3));
      disp_b_tag = TW'($urandom_range(0, 3));
      disp_dst_tag = TW'($urandom);
      cdb_valid  = ($urandom_range(0, 9) < 4);
      cdb_tag    = TW'($urandom_range(0, 3));
      cdb_data   = $urandom;
      tick();
      exp_dr = !rst;
      if (exp_dr) begin
        exp_dr = 0;
        foreach (m[i]) if (!m[i].v) exp_dr = 1;
      end
      checks++;
      if ({alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag, disp_ready} !== {m_en, m_A, m_B, m_ctrl, m_dtag, exp_dr}) begin
        failures++;
        $display("FAIL random[%0d]: got en=%b A=%h B=%h ctrl=%0d dst=%0d rdy=%b expected en=%b A=%h B=%h ctrl=%0d dst=%0d rdy=%b",
                 n, alu_en, alu_A, alu_B, alu_ctrl, alu_dst_tag, disp_ready,
                 m_en, m_A, m_B, m_ctrl, m_dtag, exp_dr);
      end
    end
    clear_inputs();
    rst = 0;
    $display("test_random: 3000 cycles compared");
  endtask

  initial begin
    rst = 1;
    alu_ready = 1;
    clear_inputs();
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_dispatch_bypass();
    test_full_stall();
    test_shared_tag();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
